mig_app_bram_emu: RTL and testbench
===================================

Name: mig_app_bram_emu

Overview:
- Synthesizable responder for the MIG 7-series user ("app") interface, backed by on-chip block RAM.
- Stands in for MIG + DDR3 on the frame-buffer path, so the DDR3 read/write arbiter can run in simulation and on boards without DDR.
- Mirrors MIG timing traits the arbiter depends on: calibration delay, app_rdy/app_wdf_rdy backpressure, in-order read return with fixed latency, no read backpressure.

Parameters:
ADDR_W, 28, app_addr width
DATA_W, 128, app data width (one 8-beat burst at 4:1)
MEM_AW, 12, log2 of memory depth in DATA_W words
CALIB_CYCLES, 64, ui_clk cycles from reset release to init_calib_complete
RD_LAT, 4, cycles from read issue to app_rd_data_valid (>=2)
STALL_EN, 1, 1 = pseudo-random app_rdy stalls enabled

Ports:
ui_clk  in  1  user clock
ui_clk_sync_rst  in  1  reset, synchronous, active-high
init_calib_complete  out  1  calibration done
app_en  in  1  command valid
app_cmd  in  3  000 write, 001 read, others illegal
app_addr  in  ADDR_W  burst address (units of 8)
app_rdy  out  1  command accepted when high with app_en
app_wdf_wren  in  1  write data valid
app_wdf_end  in  1  last beat of write burst (must equal app_wdf_wren)
app_wdf_data  in  DATA_W  write data
app_wdf_mask  in  DATA_W/8  byte mask, 1 = byte not written
app_wdf_rdy  out  1  write data accepted when high with app_wdf_wren
app_rd_data  out  DATA_W  read data
app_rd_data_valid  out  1  read data valid
app_rd_data_end  out  1  equals app_rd_data_valid
err_sticky  out  1  sticky protocol error flag

Behaviour:
- Reset (ui_clk_sync_rst high at a ui_clk edge): all outputs 0, both FIFOs flushed, read pipeline cleared, calibration counter 0, LFSR = 16'hACE1. Memory contents retained. Reset mid-operation drops all queued/in-flight commands and data with no further outputs.
- Calibration: counter increments each cycle after reset. init_calib_complete rises when the count reaches CALIB_CYCLES-1, then stays high until reset.
- Word index = app_addr[MEM_AW+2:3]. Upper address bits ignored (aliasing); bits [2:0] ignored.
- Command FIFO: depth 4; entry {cmd, index}.
  - app_rdy = calib & !cmd_full & !stall.
  - Accept when app_en & app_rdy.
- Write-data FIFO: depth 4; entry {data, mask}.
  - app_wdf_rdy = calib & !wdf_full. Independent of stall.
  - Accept when app_wdf_wren & app_wdf_rdy.
  - Data may precede or follow its command by any number of cycles; pairing is strictly in order.
- Stall: 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every cycle. stall = STALL_EN & (lfsr[2:0]==0).
- Issue stage (at most one command per cycle, in order):
  - Head is write and wdf non-empty: pop both; write the memory word honouring the mask.
  - Head is write and wdf empty: wait.
  - Head is read: pop; BRAM read; data enters a valid/data shift pipeline, emerging exactly RD_LAT cycles after issue.
  - A read issued the cycle after a write to the same index returns the new data.
- Read return: no backpressure. Back-to-back reads give back-to-back valid.
- Simultaneous events: a FIFO push and pop in the same cycle keeps the count unchanged and is legal when full (the pop frees the slot).
- err_sticky is set on any of:
  - app_en with an illegal app_cmd (command dropped, app_rdy unaffected);
  - app_wdf_wren != app_wdf_end;
  - app_en or app_wdf_wren before calibration completes.
  It clears only on reset.

Decomposition:
- Package mig_emu_pkg: CMD_WRITE=3'b000, CMD_READ=3'b001, LFSR_SEED=16'hACE1, LFSR taps.
- Sub-module mig_emu_sync_fifo (parameterised width/depth, count/full/empty, simultaneous push/pop). Instantiated twice.
- Memory inferred inline.

Test Plan:
- Reset, idle -> init_calib_complete low for cycles 0..62 after release, high from cycle 63. app_rdy/app_wdf_rdy 0 before that.
- STALL_EN=0: write 128'h0123... to addr 0x10, mask 0, then read 0x10 -> app_rd_data_valid exactly RD_LAT=4 cycles after read issue, data matches, app_rd_data_end=1.
- Mask 16'h00FF writing all-ones over a word previously all-zeros -> readback = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}.
- Write data sent 3 cycles before its command, and the reverse order -> memory write occurs only once both present; readback correct.
- Five back-to-back writes with no write data -> app_rdy drops after the 4th accept. Data supplied -> app_rdy recovers; 8 back-to-back reads return 8 consecutive valids in order.
- app_cmd=3'b010 with app_en -> err_sticky=1 and stays 1. Reset asserted mid-read burst -> no app_rd_data_valid afterwards, memory retained on re-read.

Source files
------------

// File: rtl/mig_emu_pkg.sv
package mig_emu_pkg;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'b000,
    CMD_READ  = 3'b001
  } app_cmd_e;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as state-bit mask [15],[13],[12],[10]
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mig_emu_sync_fifo.sv
module mig_emu_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = store[rd_ptr];

  // a pop in the same cycle frees the slot, so push is legal when full
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mig_app_bram_emu.sv
module mig_app_bram_emu
  import mig_emu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned RD_LAT       = 4,
  parameter int unsigned STALL_EN     = 1
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  output logic                init_calib_complete,
  input  logic                app_en,
  input  logic [2:0]          app_cmd,
  input  logic [ADDR_W-1:0]   app_addr,
  output logic                app_rdy,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                err_sticky
);

  localparam int unsigned    CMD_W    = 3 + MEM_AW;
  localparam int unsigned    WDF_W    = DATA_W + DATA_W / 8;
  localparam int unsigned    CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned    CAW      = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [CAW-1:0] CAL_LAST = CAW'(CALIB_CYCLES - 1);

  logic [CAW-1:0]      cal_cnt;
  logic                calib;
  logic [15:0]         lfsr;
  logic                stall;
  logic                cmd_legal;
  logic                cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMD_W-1:0]    cmd_head;
  logic [CNT_W-1:0]    cmd_count;
  logic                wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [WDF_W-1:0]    wdf_head;
  logic [CNT_W-1:0]    wdf_count;
  logic [2:0]          head_cmd;
  logic [MEM_AW-1:0]   head_idx;
  logic [MEM_AW-1:0]   idx;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_mask;
  logic                issue_wr, issue_rd;
  logic [DATA_W-1:0]   mem [2**MEM_AW];
  logic [DATA_W-1:0]   rd_q;
  logic [RD_LAT-1:0]   v_pipe;
  logic [DATA_W-1:0]   d_pipe [RD_LAT-1];
  logic                unused_ok;

  assign idx                 = app_addr[MEM_AW+2:3];
  assign calib               = (cal_cnt == CAL_LAST);
  assign init_calib_complete = calib;
  assign stall               = (STALL_EN != 0) && (lfsr[2:0] == 3'b000);
  assign app_rd_data         = d_pipe[RD_LAT-2];
  assign app_rd_data_valid   = v_pipe[RD_LAT-1];
  assign app_rd_data_end     = v_pipe[RD_LAT-1];
  assign unused_ok           = ^{app_addr[ADDR_W-1:MEM_AW+3], app_addr[2:0], cmd_count, wdf_count};

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst)  cal_cnt <= '0;
    else if (!calib)      cal_cnt <= cal_cnt + 1'b1;
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) lfsr <= LFSR_SEED;
    else                 lfsr <= lfsr_next(lfsr);
  end

  // issue is suppressed during reset so a queued write cannot land on the reset edge
  always_comb begin
    cmd_legal           = (app_cmd == CMD_WRITE) || (app_cmd == CMD_READ);
    app_rdy             = calib && !cmd_full && !stall;
    app_wdf_rdy         = calib && !wdf_full;
    cmd_push            = app_en && app_rdy && cmd_legal;
    wdf_push            = app_wdf_wren && app_wdf_rdy;
    {head_cmd, head_idx} = cmd_head;
    {wr_data, wr_mask}   = wdf_head;
    issue_rd            = !ui_clk_sync_rst && !cmd_empty && (head_cmd == CMD_READ);
    issue_wr            = !ui_clk_sync_rst && !cmd_empty && (head_cmd == CMD_WRITE) && !wdf_empty;
    cmd_pop             = issue_rd || issue_wr;
    wdf_pop             = issue_wr;
  end

  mig_emu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk       (ui_clk),
    .rst       (ui_clk_sync_rst),
    .push      (cmd_push),
    .push_data ({app_cmd, idx}),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .count     (cmd_count),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  mig_emu_sync_fifo #(.WIDTH(WDF_W), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
    .clk       (ui_clk),
    .rst       (ui_clk_sync_rst),
    .push      (wdf_push),
    .push_data ({app_wdf_data, app_wdf_mask}),
    .pop       (wdf_pop),
    .pop_data  (wdf_head),
    .count     (wdf_count),
    .full      (wdf_full),
    .empty     (wdf_empty)
  );

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      err_sticky <= 1'b0;
    end else if ((app_en && !cmd_legal) || (app_wdf_wren != app_wdf_end) ||
                 ((app_en || app_wdf_wren) && !calib)) begin
      err_sticky <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (issue_wr) begin
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
        if (!wr_mask[b]) mem[head_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (issue_rd) rd_q <= mem[head_idx];
  end

  // data stages only load alongside a valid token, so idle data stays quiet
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      v_pipe <= '0;
      for (int unsigned i = 0; i < RD_LAT - 1; i++) d_pipe[i] <= '0;
    end else begin
      v_pipe <= {v_pipe[RD_LAT-2:0], issue_rd};
      if (v_pipe[0]) d_pipe[0] <= rd_q;
      for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
        if (v_pipe[i]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mig_app_bram_emu.sv
module tb_mig_app_bram_emu;

  localparam int unsigned CALIB = 64;
  localparam int unsigned RDL   = 4;

  logic         ui_clk = 1'b0;
  logic         ui_clk_sync_rst = 1'b1;
  logic         init_calib_complete;
  logic         app_en = 1'b0;
  logic [2:0]   app_cmd = 3'b000;
  logic [27:0]  app_addr = '0;
  logic         app_rdy;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         err_sticky;

  mig_app_bram_emu #(
    .ADDR_W(28), .DATA_W(128), .MEM_AW(12),
    .CALIB_CYCLES(CALIB), .RD_LAT(RDL), .STALL_EN(0)
  ) dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .err_sticky          (err_sticky)
  );

  always #5 ui_clk = ~ui_clk;

  // reference model: commands, write data and expected returns as plain queues
  typedef struct { bit is_read; int unsigned idx; } cmd_t;
  typedef struct { logic [127:0] data; logic [15:0] mask; } wd_t;
  typedef struct { int unsigned due; logic [127:0] data; } rd_t;

  cmd_t         cq[$];
  wd_t          wq[$];
  rd_t          rq[$];
  logic [127:0] mem_m [4096];
  int unsigned  cyc;
  bit           err_m;
  bit           acc_c, acc_d;
  int           total = 0;
  int           bad = 0;
  int unsigned  pool [8] = '{2, 4, 7, 100, 4095, 0, 2048, 33};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // check this cycle's outputs, advance the model across the next edge, then clock
  task automatic step();
    bit          calib_m, rdy_m, wrdy_m;
    int unsigned i;
    calib_m = (cyc >= CALIB - 1);
    rdy_m   = calib_m && (cq.size() < 4);
    wrdy_m  = calib_m && (wq.size() < 4);
    chk("calib", init_calib_complete, calib_m);
    chk("app_rdy", app_rdy, rdy_m);
    chk("app_wdf_rdy", app_wdf_rdy, wrdy_m);
    chk("err_sticky", err_sticky, err_m);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("rd_valid", app_rd_data_valid, 1'b1);
      chk("rd_end", app_rd_data_end, 1'b1);
      chk("rd_data", app_rd_data, rq[0].data);
      void'(rq.pop_front());
    end else begin
      chk("rd_valid_idle", app_rd_data_valid, 1'b0);
      chk("rd_end_idle", app_rd_data_end, 1'b0);
    end
    if (cq.size() > 0) begin
      if (cq[0].is_read) begin
        rq.push_back('{due: cyc + RDL, data: mem_m[cq[0].idx]});
        void'(cq.pop_front());
      end else if (wq.size() > 0) begin
        i = cq[0].idx;
        for (int b = 0; b < 16; b++)
          if (!wq[0].mask[b]) mem_m[i][b*8 +: 8] = wq[0].data[b*8 +: 8];
        void'(cq.pop_front());
        void'(wq.pop_front());
      end
    end
    acc_c = 0;
    acc_d = 0;
    if (app_en) begin
      if (!calib_m) err_m = 1;
      if (app_cmd == 3'b000 || app_cmd == 3'b001) begin
        if (rdy_m) begin
          cq.push_back('{is_read: (app_cmd == 3'b001), idx: int'(app_addr[14:3])});
          acc_c = 1;
        end
      end else begin
        err_m = 1;
      end
    end
    if (app_wdf_wren) begin
      if (!calib_m) err_m = 1;
      if (wrdy_m) begin
        wq.push_back('{data: app_wdf_data, mask: app_wdf_mask});
        acc_d = 1;
      end
    end
    if (app_wdf_wren != app_wdf_end) err_m = 1;
    cyc++;
    @(posedge ui_clk);
    #1;
  endtask

  task automatic idle(input int n);
    app_en = 0; app_wdf_wren = 0; app_wdf_end = 0;
    repeat (n) step();
  endtask

  task automatic xfer(input bit do_c, input logic [2:0] c, input logic [27:0] a,
                      input bit do_d, input logic [127:0] d, input logic [15:0] m);
    bit pc, pd;
    int n;
    pc = do_c; pd = do_d; n = 0;
    while ((pc || pd) && n < 200) begin
      app_en = pc; app_cmd = c; app_addr = a;
      app_wdf_wren = pd; app_wdf_end = pd; app_wdf_data = d; app_wdf_mask = m;
      step();
      if (acc_c) pc = 0;
      if (acc_d) pd = 0;
      n++;
    end
    app_en = 0; app_wdf_wren = 0; app_wdf_end = 0;
    total++;
    assert (!(pc || pd)) else begin
      bad++;
      $error("FAIL xfer_timeout observed=pending expected=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cq.size() > 0 || rq.size() > 0) && n < 100) begin
      idle(1);
      n++;
    end
    total++;
    assert (cq.size() == 0 && rq.size() == 0) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", cq.size() + rq.size());
    end
  endtask

  task automatic do_reset();
    ui_clk_sync_rst = 1;
    app_en = 0; app_wdf_wren = 0; app_wdf_end = 0;
    @(posedge ui_clk);
    #1;
    ui_clk_sync_rst = 0;
    cq.delete(); wq.delete(); rq.delete();
    err_m = 0;
    cyc = 0;
    chk("reset_rd_data", app_rd_data, '0);
  endtask

  function automatic logic [27:0] mk_addr(input int unsigned idx);
    logic [27:0] a;
    a = 28'($urandom);
    a[14:3] = 12'(idx);
    return a;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d;
    logic [15:0]  m;
    logic [27:0]  a;

    do_reset();
    idle(CALIB + 2);

    xfer(1, 3'b000, 28'h10, 1, 128'h0123456789ABCDEF_FEDCBA9876543210, '0);
    xfer(1, 3'b001, 28'h10, 0, '0, '0);
    drain();

    xfer(1, 3'b000, 28'h20, 1, '0, '0);
    xfer(1, 3'b000, 28'h20, 1, '1, 16'h00FF);
    xfer(1, 3'b001, 28'h20, 0, '0, '0);
    drain();

    xfer(0, 3'b000, '0, 1, 128'hA5A5_0001, '0);
    idle(3);
    xfer(1, 3'b000, mk_addr(7), 0, '0, '0);
    xfer(1, 3'b000, mk_addr(100), 0, '0, '0);
    idle(3);
    xfer(0, 3'b000, '0, 1, 128'h5A5A_0002, '0);
    xfer(1, 3'b001, mk_addr(7), 0, '0, '0);
    xfer(1, 3'b001, mk_addr(100), 0, '0, '0);
    drain();

    for (int k = 0; k < 8; k++) xfer(1, 3'b000, mk_addr(pool[k]), 1, rnd128(), '0);
    drain();

    for (int k = 0; k < 4; k++) xfer(1, 3'b000, mk_addr(10 + k), 0, '0, '0);
    app_en = 1; app_cmd = 3'b000; app_addr = mk_addr(14);
    repeat (3) step();
    xfer(1, 3'b000, mk_addr(14), 1, rnd128(), '0);
    for (int k = 0; k < 4; k++) xfer(0, 3'b000, '0, 1, rnd128(), 16'($urandom));
    for (int k = 0; k < 8; k++) xfer(1, 3'b001, mk_addr(10 + (k % 5)), 0, '0, '0);
    drain();

    for (int k = 0; k < 150; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      d = rnd128();
      m = ($urandom_range(0, 2) == 0) ? 16'($urandom) : '0;
      a = mk_addr(pool[$urandom_range(0, 7)]);
      if (r <= 3) begin
        xfer(1, 3'b000, a, 1, d, m);
      end else if (r == 4) begin
        xfer(0, 3'b000, a, 1, d, m);
        idle($urandom_range(0, 3));
        xfer(1, 3'b000, a, 0, d, m);
      end else if (r == 5) begin
        xfer(1, 3'b000, a, 0, d, m);
        idle($urandom_range(0, 3));
        xfer(0, 3'b000, a, 1, d, m);
      end else if (r <= 8) begin
        xfer(1, 3'b001, a, 0, '0, '0);
      end else begin
        idle($urandom_range(1, 3));
      end
    end
    drain();

    app_en = 1; app_cmd = 3'b010; app_addr = 28'h40;
    step();
    idle(3);

    for (int k = 0; k < 6; k++) xfer(1, 3'b001, mk_addr(pool[k]), 0, '0, '0);
    idle(2);
    do_reset();
    idle(CALIB + 2);
    for (int k = 0; k < 8; k++) xfer(1, 3'b001, mk_addr(pool[k]), 0, '0, '0);
    drain();

    app_wdf_wren = 1; app_wdf_end = 0; app_wdf_data = rnd128(); app_wdf_mask = '0;
    step();
    idle(3);

    do_reset();
    idle(5);
    app_en = 1; app_cmd = 3'b001; app_addr = 28'h10;
    step();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
